// File: rtl/toggle_pkg.sv
// Shared types and defaults for the toggle-signalling receiver.
package toggle_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_CNT_W       = 4;
   localparam int DEF_TOTAL_W     = 16;

   function automatic int cnt_max(input int width);
      return (1 << width) - 1;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Falling-edge flop chain that brings an asynchronous level into the clk domain.
module sync_chain #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] stages;

   always_ff @(negedge clk) begin
      if (rst) stages <= '0;
      else     stages <= {stages[SYNC_STAGES-2:0], d};
   end

   assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Toggle-line event receiver: synchronise, detect level changes, queue them for a
// valid/ready consumer. Optional evt_pulse output under TOGGLE_EVENT_RX_PULSE_OUT_EN.
module toggle_event_rx
   import toggle_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TOTAL_W     = DEF_TOTAL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tog_in,
   input  logic               evt_ready,
   input  logic               clr_ovf,
   output logic               evt_valid,
   output logic [CNT_W-1:0]   pending,
   output logic [TOTAL_W-1:0] total_cnt,
   output logic               overflow
`ifdef TOGGLE_EVENT_RX_PULSE_OUT_EN
   ,
   output logic               evt_pulse
`endif
);

   localparam int                 INIT_W    = $clog2(SYNC_STAGES + 1);
   localparam logic [INIT_W-1:0]  INIT_LAST = INIT_W'(SYNC_STAGES);
   localparam logic [CNT_W-1:0]   PEND_MAX  = CNT_W'(cnt_max(CNT_W));

   state_t              state;
   state_t              state_nxt;
   logic [INIT_W-1:0]   init_cnt;
   logic                sync_out;
   logic                prev;
   logic                run;
   logic                detect;
   logic                handshake;
   logic                ovf_set;
   logic [CNT_W-1:0]    pending_nxt;

   // Saturating pending update; returns the new count and whether an event was lost.
   function automatic logic [CNT_W:0] next_pending(input logic [CNT_W-1:0] cur,
                                                   input logic             det,
                                                   input logic             hs);
      logic [CNT_W-1:0] nxt;
      logic             lost;
      nxt  = cur;
      lost = 1'b0;
      case ({det, hs})
         2'b10: begin
            if (cur == PEND_MAX) lost = 1'b1;
            else                 nxt  = cur + CNT_W'(1);
         end
         2'b01:   nxt = cur - CNT_W'(1);
         default: nxt = cur;
      endcase
      return {lost, nxt};
   endfunction

   sync_chain #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (tog_in),
      .q   (sync_out)
   );

   always_ff @(negedge clk) begin
      if (rst) state <= ST_INIT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_INIT: if (init_cnt == INIT_LAST) state_nxt = ST_RUN;
         ST_RUN:  state_nxt = ST_RUN;
         default: state_nxt = ST_INIT;
      endcase
   end

   always_comb begin
      run = (state == ST_RUN);
   end

   always_ff @(negedge clk) begin
      if (rst)
         init_cnt <= '0;
      else if (state == ST_INIT && init_cnt != INIT_LAST)
         init_cnt <= init_cnt + INIT_W'(1);
   end

   // prev tracks the synchronised level in both states, so ST_INIT learns the idle level.
   always_ff @(negedge clk) begin
      if (rst) prev <= 1'b0;
      else     prev <= sync_out;
   end

   assign detect    = run & (sync_out ^ prev);
   assign evt_valid = (pending != '0);
   assign handshake = evt_valid & evt_ready;

   always_comb begin
      {ovf_set, pending_nxt} = next_pending(pending, detect, handshake);
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         pending   <= '0;
         total_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         pending <= pending_nxt;
         if (detect) total_cnt <= total_cnt + TOTAL_W'(1);
         if (ovf_set)      overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

`ifdef TOGGLE_EVENT_RX_PULSE_OUT_EN
   always_ff @(negedge clk) begin
      if (rst) evt_pulse <= 1'b0;
      else     evt_pulse <= detect;
   end
`endif

endmodule

// File: tb/tb_toggle_event_rx.sv
// Self-checking bench for toggle_event_rx against a delayed-sample event model.
module tb_toggle_event_rx;

   localparam int S       = 2;
   localparam int CNT_W   = 4;
   localparam int TOTAL_W = 16;
   localparam int PMAX    = (1 << CNT_W) - 1;

   logic               clk;
   logic               rst;
   logic               tog_in;
   logic               evt_ready;
   logic               clr_ovf;
   logic               evt_valid;
   logic [CNT_W-1:0]   pending;
   logic [TOTAL_W-1:0] total_cnt;
   logic               overflow;
`ifdef TOGGLE_EVENT_RX_PULSE_OUT_EN
   logic               evt_pulse;
`endif

   int errors = 0;
   int checks = 0;

   // reference model state
   bit hist[$];
   int m_pend, m_total, m_ovf, m_since, m_pulse;

   toggle_event_rx #(
      .SYNC_STAGES(S),
      .CNT_W      (CNT_W),
      .TOTAL_W    (TOTAL_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tog_in    (tog_in),
      .evt_ready (evt_ready),
      .clr_ovf   (clr_ovf),
      .evt_valid (evt_valid),
      .pending   (pending),
      .total_cnt (total_cnt),
      .overflow  (overflow)
`ifdef TOGGLE_EVENT_RX_PULSE_OUT_EN
      ,
      .evt_pulse (evt_pulse)
`endif
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   // An event is seen S edges after its sample, once S+1 post-reset edges have passed.
   task automatic model_step();
      bit det, hs;
      int n;
      if (rst) begin
         hist.push_back(1'b0);
         m_pend = 0; m_total = 0; m_ovf = 0; m_since = 0; m_pulse = 0;
      end else begin
         m_since++;
         hist.push_back(tog_in);
         n   = hist.size();
         det = (m_since >= S + 2) && (hist[n-1-S] != hist[n-2-S]);
         hs  = (m_pend != 0) && evt_ready;
         m_pulse = det;
         if (det) m_total = (m_total + 1) % (1 << TOTAL_W);
         if (det && !hs) begin
            if (m_pend == PMAX) m_ovf = 1;
            else                m_pend++;
         end else if (hs && !det) begin
            m_pend--;
         end
         if (!(det && !hs && m_pend == PMAX && m_ovf == 1 && hs == 0 && det) && clr_ovf) begin
            // set wins over clear: only clear when this edge did not lose an event
         end
      end
      while (hist.size() > 8) void'(hist.pop_front());
   endtask

   bit lost_now;
   task automatic tick();
      int pend_before;
      bit det_lost;
      pend_before = m_pend;
      @(negedge clk);
      begin
         int ovf_before;
         ovf_before = m_ovf;
         m_ovf = 0;
         model_step();
         lost_now = (m_ovf == 1);
         if (rst)             m_ovf = 0;
         else if (lost_now)   m_ovf = 1;
         else if (clr_ovf)    m_ovf = 0;
         else                 m_ovf = ovf_before;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; evt_ready = 1'b0; clr_ovf = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      repeat (10) tick();
   endtask

   task automatic toggle_wait(input int n);
      tog_in = ~tog_in;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      tog_in = 1'b1;
      do_reset();
      checks++; if (pending !== '0)  begin errors++; $display("FAIL reset_pending got=%0d exp=0", pending); end
      checks++; if (total_cnt !== '0) begin errors++; $display("FAIL reset_total got=%0d exp=0", total_cnt); end
      checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
   endtask

   task automatic test_single();
      evt_ready = 1'b0;
      tog_in = ~tog_in;
      tick();
      checks++; if (pending !== 4'd0) begin errors++; $display("FAIL single_e1 got=%0d exp=0", pending); end
      tick();
      checks++; if (pending !== 4'd0) begin errors++; $display("FAIL single_e2 got=%0d exp=0", pending); end
      tick();
      checks++; if (pending !== 4'd1 || evt_valid !== 1'b1)
         begin errors++; $display("FAIL single_e3 got pend=%0d vld=%b exp pend=1 vld=1", pending, evt_valid); end
      checks++; if (total_cnt !== 16'd1) begin errors++; $display("FAIL single_total got=%0d exp=1", total_cnt); end
   endtask

   task automatic test_saturate();
      do_reset();
      for (int i = 0; i < 16; i++) toggle_wait(4);
      repeat (4) tick();
      checks++; if (pending !== 4'd15) begin errors++; $display("FAIL sat_pending got=%0d exp=15", pending); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf got=%b exp=1", overflow); end
      checks++; if (total_cnt !== 16'd16) begin errors++; $display("FAIL sat_total got=%0d exp=16", total_cnt); end
   endtask

   task automatic test_ovf_clr();
      clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_alone got=%b exp=0", overflow); end
      tog_in = ~tog_in;
      repeat (2) tick();
      clr_ovf = 1'b1; tick();
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL set_wins got=%b exp=1", overflow); end
      tick(); clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_next got=%b exp=0", overflow); end
      checks++; if (pending !== 4'd15 || total_cnt !== 16'd17)
         begin errors++; $display("FAIL ovf_counts got pend=%0d tot=%0d exp pend=15 tot=17", pending, total_cnt); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 3; i++) toggle_wait(4);
      checks++; if (pending !== 4'd3) begin errors++; $display("FAIL b2b_pre got=%0d exp=3", pending); end
      tog_in = ~tog_in;
      repeat (2) tick();
      evt_ready = 1'b1; tick(); evt_ready = 1'b0;
      checks++; if (pending !== 4'd3) begin errors++; $display("FAIL b2b_pending got=%0d exp=3", pending); end
      checks++; if (total_cnt !== 16'd4) begin errors++; $display("FAIL b2b_total got=%0d exp=4", total_cnt); end
      evt_ready = 1'b1; tick(); evt_ready = 1'b0;
      checks++; if (pending !== 4'd2) begin errors++; $display("FAIL drain_one got=%0d exp=2", pending); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) toggle_wait(4);
      checks++; if (pending !== 4'd5) begin errors++; $display("FAIL mid_pre got=%0d exp=5", pending); end
      rst = 1'b1; tog_in = ~tog_in; tick(); rst = 1'b0;
      checks++; if (pending !== 4'd0 || evt_valid !== 1'b0)
         begin errors++; $display("FAIL mid_rst got pend=%0d vld=%b exp 0 0", pending, evt_valid); end
      repeat (10) tick();
      checks++; if (pending !== 4'd0 || total_cnt !== 16'd0)
         begin errors++; $display("FAIL mid_inflight got pend=%0d tot=%0d exp 0 0", pending, total_cnt); end
   endtask

   task automatic test_random();
      int hold;
      do_reset();
      hold = 0;
      for (int c = 0; c < 600; c++) begin
         if (hold == 0 && $urandom_range(0, 2) == 0) begin
            tog_in = ~tog_in;
            hold   = S + 1;
         end
         evt_ready = ((c / 100) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
         clr_ovf   = ($urandom_range(0, 15) == 0);
         tick();
         if (hold > 0) hold--;
         checks++;
         if (pending !== CNT_W'(m_pend) || total_cnt !== TOTAL_W'(m_total) ||
             overflow !== m_ovf[0] || evt_valid !== (m_pend != 0)) begin
            errors++;
            $display("FAIL random c=%0d got pend=%0d tot=%0d ovf=%b vld=%b exp pend=%0d tot=%0d ovf=%0d",
                     c, pending, total_cnt, overflow, evt_valid, m_pend, m_total, m_ovf);
         end
`ifdef TOGGLE_EVENT_RX_PULSE_OUT_EN
         checks++;
         if (evt_pulse !== m_pulse[0]) begin
            errors++;
            $display("FAIL pulse c=%0d got=%b exp=%0d", c, evt_pulse, m_pulse);
         end
`endif
      end
      evt_ready = 1'b0; clr_ovf = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) hist.push_back(1'b0);
      m_pend = 0; m_total = 0; m_ovf = 0; m_since = 0; m_pulse = 0;
      rst = 1'b1; tog_in = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_single();
      test_saturate();
      test_ovf_clr();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
